// File: rtl/trivium_host_ctrl.sv
// Host-side sequencer for the trivium keystream core: byte-wide key/IV loading,
// load/warm-up sequencing and keystream-byte XOR with host data.
module trivium_host_ctrl #(
    parameter int WARMUP = 1152
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rekey,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [79:0] key,
    output logic [79:0] iv,
    output logic        core_rst,
    output logic        core_enable,
    input  logic        ks_bit
);

    localparam int WCNT_W = $clog2(WARMUP + 1);

    typedef enum logic [2:0] {
        S_LOAD_KEY,
        S_LOAD_IV,
        S_CORE_LOAD,
        S_WARM,
        S_STREAM
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          byte_cnt_q, byte_cnt_d;
    logic [79:0]         key_q, key_d;
    logic [79:0]         iv_q, iv_d;
    logic [WCNT_W-1:0]   warm_cnt_q, warm_cnt_d;
    logic [3:0]          ks_cnt_q, ks_cnt_d;
    logic [7:0]          ks_byte_q, ks_byte_d;
    logic [7:0]          out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                ks_full;
    logic                xfer;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        key_d       = key_q;
        iv_d        = iv_q;
        warm_cnt_d  = warm_cnt_q;
        ks_cnt_d    = ks_cnt_q;
        ks_byte_d   = ks_byte_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;
        core_rst    = 1'b0;
        core_enable = 1'b0;
        ks_full     = (ks_cnt_q == 4'd8);

        // rekey masks every strobe in its own cycle so the core is left untouched
        if (!rekey) begin
            case (state_q)
                S_LOAD_KEY, S_LOAD_IV: in_ready = 1'b1;
                S_CORE_LOAD:           core_rst = 1'b1;
                S_WARM:                core_enable = 1'b1;
                S_STREAM: begin
                    in_ready    = ks_full && (!out_valid_q || out_ready);
                    core_enable = !ks_full;
                end
                default: ;
            endcase
        end

        xfer = in_valid && in_ready;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (rekey) begin
            state_d     = S_LOAD_KEY;
            byte_cnt_d  = 4'd0;
            ks_cnt_d    = 4'd0;
            warm_cnt_d  = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_LOAD_KEY: begin
                    if (xfer) begin
                        key_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
                        if (byte_cnt_q == 4'd9) begin
                            byte_cnt_d = 4'd0;
                            state_d    = S_LOAD_IV;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 4'd1;
                        end
                    end
                end
                S_LOAD_IV: begin
                    if (xfer) begin
                        iv_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
                        if (byte_cnt_q == 4'd9) begin
                            byte_cnt_d = 4'd0;
                            state_d    = S_CORE_LOAD;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 4'd1;
                        end
                    end
                end
                S_CORE_LOAD: begin
                    warm_cnt_d = '0;
                    state_d    = S_WARM;
                end
                S_WARM: begin
                    if (warm_cnt_q == WCNT_W'(WARMUP - 1)) begin
                        warm_cnt_d = '0;
                        ks_cnt_d   = 4'd0;
                        state_d    = S_STREAM;
                    end else begin
                        warm_cnt_d = warm_cnt_q + 1'b1;
                    end
                end
                S_STREAM: begin
                    // first collected bit lands in the LSB
                    if (core_enable) begin
                        ks_byte_d[ks_cnt_q[2:0]] = ks_bit;
                        ks_cnt_d = ks_cnt_q + 4'd1;
                    end
                    if (xfer) begin
                        out_data_d  = in_data ^ ks_byte_q;
                        out_valid_d = 1'b1;
                        ks_cnt_d    = 4'd0;
                    end
                end
                default: state_d = S_LOAD_KEY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD_KEY;
            byte_cnt_q  <= 4'd0;
            key_q       <= '0;
            iv_q        <= '0;
            warm_cnt_q  <= '0;
            ks_cnt_q    <= 4'd0;
            ks_byte_q   <= 8'd0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            key_q       <= key_d;
            iv_q        <= iv_d;
            warm_cnt_q  <= warm_cnt_d;
            ks_cnt_q    <= ks_cnt_d;
            ks_byte_q   <= ks_byte_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign key       = key_q;
    assign iv        = iv_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_trivium_host_ctrl.sv
// Bench for trivium_host_ctrl: a stub core supplies a known keystream pattern and
// a scoreboard holds the expected ciphertext bytes until the controller emits them.
module tb_trivium_host_ctrl;

    localparam int WARMUP = 1152;
    localparam int LIMIT  = WARMUP + 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        rekey;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [79:0] key;
    logic [79:0] iv;
    logic        core_rst;
    logic        core_enable;
    logic        ks_bit;

    int n_checks = 0;
    int n_fail   = 0;
    int mode     = 0;
    int steps    = 0;
    int steps_nxt = 0;
    int run      = 0;
    int last_run = 0;
    int kidx     = 0;
    bit streaming = 1'b0;
    logic [7:0] sb[$];

    trivium_host_ctrl #(.WARMUP(WARMUP)) dut (
        .clk        (clk),
        .rst        (rst),
        .rekey      (rekey),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .key        (key),
        .iv         (iv),
        .core_rst   (core_rst),
        .core_enable(core_enable),
        .ks_bit     (ks_bit)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // stub core keystream: bit produced at the given enabled-step index since load
    function automatic logic ks_fn(input int m, input int s);
        case (m)
            0:       return 1'b1;
            1:       return ~s[0];
            default: return s[0] ^ s[2] ^ s[3] ^ s[6];
        endcase
    endfunction

    function automatic logic [7:0] exp_ks(input int m, input int k);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = ks_fn(m, WARMUP + 8 * k + j);
        return r;
    endfunction

    assign ks_bit = ks_fn(mode, steps);

    always @(posedge clk) steps <= steps_nxt;

    always @(negedge clk) begin
        steps_nxt = core_rst ? 0 : (core_enable ? steps + 1 : steps);
        if (!rst) begin
            if (core_enable) run++;
            else if (run != 0) begin
                last_run = run;
                run = 0;
            end
            if (out_valid && out_ready) begin
                check_eq("sb_nonempty", 80'(sb.size() != 0), 80'd1);
                if (sb.size() != 0) check_eq("out_data", 80'(out_data), 80'(sb.pop_front()));
            end
            if (streaming && in_valid && in_ready) begin
                sb.push_back(in_data ^ exp_ks(mode, kidx));
                kidx++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("in_ready_timeout", 80'(ok), 80'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load_all();
        streaming = 1'b0;
        kidx = 0;
        for (int i = 0; i < 10; i++) send_byte(8'(i + 1));
        check_eq("key", key, 80'h0A090807060504030201);
        for (int i = 0; i < 10; i++) send_byte(8'(8'hF0 + i));
        check_eq("iv", iv, 80'hF9F8F7F6F5F4F3F2F1F0);
        @(negedge clk);
        check_eq("core_rst_pulse", 80'(core_rst), 80'd1);
        check_eq("enable_in_load", 80'(core_enable), 80'd0);
        @(negedge clk);
        check_eq("core_rst_end", 80'(core_rst), 80'd0);
        check_eq("enable_start", 80'(core_enable), 80'd1);
        streaming = 1'b1;
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
        check_eq("drained", 80'(sb.size()), 80'd0);
    endtask

    task automatic do_rekey();
        rekey = 1'b1;
        @(negedge clk);
        check_eq("rekey_enable", 80'(core_enable), 80'd0);
        check_eq("rekey_core_rst", 80'(core_rst), 80'd0);
        check_eq("rekey_in_ready", 80'(in_ready), 80'd0);
        tick();
        rekey = 1'b0;
        streaming = 1'b0;
        sb.delete();
        @(negedge clk);
        check_eq("post_rekey_out_valid", 80'(out_valid), 80'd0);
        check_eq("post_rekey_enable", 80'(core_enable), 80'd0);
        check_eq("post_rekey_in_ready", 80'(in_ready), 80'd1);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rekey = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hAA;
        out_ready = 1'b1;
        mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_key", key, 80'd0);
        check_eq("rst_iv", iv, 80'd0);
        check_eq("rst_core_rst", 80'(core_rst), 80'd0);
        check_eq("rst_enable", 80'(core_enable), 80'd0);
        check_eq("rst_out_valid", 80'(out_valid), 80'd0);
        check_eq("rst_out_data", 80'(out_data), 80'd0);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("in_ready_after_rst", 80'(in_ready), 80'd1);
        check_eq("key_no_capture", key, 80'd0);
        tick();

        // constant-one keystream
        load_all();
        send_byte(8'h3C);
        check_eq("enable_run", 80'(last_run), 80'(WARMUP + 8));
        check_eq("first_exp_c3", 80'(sb.size() != 0 ? sb[0] : 8'h00), 80'hC3);
        drain();
        send_byte(8'h81);
        send_byte(8'h00);
        drain();

        // backpressure with the next keystream byte ready
        out_ready = 1'b0;
        send_byte(8'h11);
        in_valid = 1'b1;
        in_data  = 8'h22;
        repeat (12) tick();
        @(negedge clk);
        check_eq("bp_in_ready", 80'(in_ready), 80'd0);
        check_eq("bp_enable", 80'(core_enable), 80'd0);
        check_eq("bp_out_valid", 80'(out_valid), 80'd1);
        check_eq("bp_out_data_held", 80'(out_data), 80'(8'h11 ^ 8'hFF));
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release_in_ready", 80'(in_ready), 80'd1);
        tick();
        in_valid = 1'b0;
        drain();

        // rekey with a pending output byte
        out_ready = 1'b0;
        send_byte(8'h5A);
        repeat (3) tick();
        check_eq("pending_out_valid", 80'(out_valid), 80'd1);
        do_rekey();
        out_ready = 1'b1;

        // alternating keystream
        mode = 1;
        load_all();
        send_byte(8'h00);
        check_eq("enable_run_reload", 80'(last_run), 80'(WARMUP + 8));
        check_eq("alt_exp_55", 80'(sb.size() != 0 ? sb[0] : 8'h00), 80'h55);
        send_byte(8'hFF);
        drain();
        do_rekey();

        // irregular keystream, rekey in the middle of warm-up
        mode = 2;
        load_all();
        repeat (500) tick();
        do_rekey();
        load_all();
        for (int i = 0; i < 5; i++) begin
            send_byte(8'($urandom_range(0, 255)));
            if (i == 0) check_eq("enable_run_after_warm_rekey", 80'(last_run), 80'(WARMUP + 8));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trivium_host_ctrl.md
Name: trivium_host_ctrl

Overview:
- Host-side controller for the trivium keystream core; it is the other end of that core's key/iv/keystream interface.
- Accepts key and IV bytes over a byte-wide valid/ready input and presents them as 80-bit vectors to the core.
- Sequences the core's load and warm-up phases.
- Packs keystream bits into bytes and XORs each with a host data byte to produce cipher/plain output bytes.
- Sits between the tt_um pin wrapper (ui_in/uo_out) and the trivium instance, replacing the wide test-only key/iv ports.

Parameters:
- WARMUP, 1152, number of enabled core cycles after load whose keystream bits are discarded (4×288).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active high
- rekey  input  1  one-cycle request to restart key/IV loading
- in_data  input  8  key/IV/data byte from host
- in_valid  input  1  in_data valid
- in_ready  output  1  controller accepts in_data this cycle
- out_data  output  8  in_data XOR keystream byte
- out_valid  output  1  out_data valid
- out_ready  input  1  host accepts out_data
- key  output  80  key vector to core
- iv  output  80  IV vector to core
- core_rst  output  1  one-cycle load strobe to core (core loads key/iv, clears state)
- core_enable  output  1  core advances one step when high
- ks_bit  input  1  core keystream bit for current core state

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=LOAD_KEY; byte_cnt=0; key=0; iv=0.
  - core_rst=0; core_enable=0; out_valid=0; out_data=0.
  - ks_byte=0; ks_cnt=0; warmup counter=0.
- Input handshake: a byte is transferred when in_valid & in_ready at a clk edge.
- in_ready is combinational:
  - Forced 0 whenever rekey=1.
  - Otherwise 1 in LOAD_KEY and LOAD_IV.
  - Otherwise 1 in STREAM when ks_cnt==8 and (out_valid==0 or out_ready==1).
  - Otherwise 0.
- LOAD_KEY:
  - Byte n (n=0..9) is written to key[8n+7:8n].
  - On the 10th transfer: byte_cnt→0, go to LOAD_IV.
- LOAD_IV:
  - Byte n is written to iv[8n+7:8n].
  - On the 10th transfer: go to CORE_LOAD.
- CORE_LOAD: exactly one cycle with core_rst=1 and core_enable=0, then WARM.
- WARM:
  - core_enable=1 for exactly WARMUP consecutive cycles; ks_bit is ignored.
  - Then go to STREAM with ks_cnt=0.
- STREAM, keystream collection:
  - core_enable=1 iff ks_cnt<8.
  - Each such cycle: ks_byte[ks_cnt]←ks_bit (first bit → LSB), ks_cnt+1.
  - At ks_cnt==8 the core is stalled (core_enable=0) until the byte is consumed.
- STREAM, data transfer (in_valid & in_ready):
  - out_data←in_data^ks_byte, out_valid←1, ks_cnt←0.
  - Collection of the next byte starts in the following cycle.
- Output handshake: out_valid clears on out_valid & out_ready unless a new transfer loads it in the same cycle, in which case it stays 1 with new data.
- Throughput: one byte per 9 cycles maximum.
- Latency:
  - Last IV byte accepted at edge T → core_rst high in cycle T+1.
  - core_enable high cycles T+2 .. T+1+WARMUP.
  - First keystream byte complete after 8 further cycles.
  - out_valid rises at the edge following the data transfer.
- rekey=1 (not in reset), from any state:
  - At the next edge: state→LOAD_KEY; byte_cnt, ks_cnt and warmup counter cleared; out_valid→0 (pending output dropped).
  - core_enable=0 and core_rst=0 in that cycle.
  - key/iv retain old values until overwritten.
- rst has priority over rekey.
- No pin changes occur outside these rules. Host-side backpressure (out_ready=0) never loses data: in_ready stays 0 while out_valid=1 and out_ready=0.

Test Plan:
1. Reset: hold rst 3 cycles with in_valid=1 → all outputs 0, key/iv 0; in_ready=1 after release.
2. Load key bytes 0x01..0x0A then IV bytes 0xF0..0xF9 → key=0x0A09...0201, iv=0xF9F8...F1F0. core_rst high exactly 1 cycle after the 20th byte. core_enable high exactly 1152 consecutive cycles, then 8 more.
3. Stub core ks_bit=1 constant, in_data=0x3C after warm-up → out_data=0xC3, out_valid=1.
4. Stub core ks_bit alternating 1,0,1,0… from the first STREAM cycle, in_data=0x00 → out_data=0x55.
5. Backpressure: out_ready=0 with output pending and next keystream byte full → in_ready=0, core_enable=0, out_data held. Raise out_ready → next byte accepted the same cycle.
6. rekey asserted mid-WARM (cycle 500) and mid-STREAM with out_valid=1 → next cycle state LOAD_KEY, out_valid=0, core_enable=0. Reload sequence repeats scenario 2 timing exactly.
